uart_tx_sched: RTL and testbench

//  Two-requester UART transmit scheduler and serializer controller for the tx path.

---
 rtl/uart_tx_sched.sv | 207 ++++++++++++++++++++
 tb/tb_uart_tx_sched.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
// -----------------------------------------------------------------------------
// uart_tx_sched
//   Two-requester UART transmit scheduler and 8N1 serializer.
//   Round-robin arbitration between two byte sources (valid/ready), then one
//   frame per accepted byte on o_serial_out:
//     start bit (0), D0..D7 LSB first, stop bit (1).
//   Each bit lasts CLKS_PER_BIT clock cycles. Bit timing comes from i_clk.
//
// Handshake:
//   A byte moves when valid and ready are both high at a rising i_clk edge.
//   - A requester holds its valid and data stable until that edge.
//   - Ready is only offered in IDLE, and to at most one requester per cycle.
//   - Ready is forced low while i_clr is low.
//
// Parameters
//   CLKS_PER_BIT  clock cycles per serial bit (>= 2)
//
// Ports
//   i_clk          system clock, rising edge
//   i_clr          asynchronous active-low reset
//   i_req0_valid   requester 0 has a byte
//   i_req0_data    requester 0 byte, sampled on acceptance
//   o_req0_ready   requester 0 byte accepted this cycle
//   i_req1_valid   requester 1 has a byte
//   i_req1_data    requester 1 byte, sampled on acceptance
//   o_req1_ready   requester 1 byte accepted this cycle
//   o_serial_out   UART line (registered, idles high)
//   o_busy         frame in progress (START/DATA/STOP)
//   o_grant_id     requester whose frame is current or was last sent
//   o_state        FSM state for observation (0=IDLE,1=START,2=DATA,3=STOP)
// -----------------------------------------------------------------------------
module uart_tx_sched #(
   parameter int unsigned CLKS_PER_BIT = 16
) (
   input  logic       i_clk,
   input  logic       i_clr,
   input  logic       i_req0_valid,
   input  logic [7:0] i_req0_data,
   output logic       o_req0_ready,
   input  logic       i_req1_valid,
   input  logic [7:0] i_req1_data,
   output logic       o_req1_ready,
   output logic       o_serial_out,
   output logic       o_busy,
   output logic       o_grant_id,
   output logic [1:0] o_state
);

   localparam int unsigned CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST_CYC = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_DATA  = 2'd2,
      S_STOP  = 2'd3
   } state_t;

   // Registered state
   state_t        r_state;
   logic [CW-1:0] r_cyc_cnt;
   logic [2:0]    r_bit_cnt;
   logic [7:0]    r_shift;
   logic          r_serial;
   logic          r_grant_id;
   logic          r_last_served;

   // Next-state values
   state_t        w_state_nxt;
   logic [CW-1:0] w_cyc_nxt;
   logic [2:0]    w_bit_nxt;
   logic [7:0]    w_shift_nxt;
   logic          w_serial_nxt;
   logic          w_grant_id_nxt;
   logic          w_last_nxt;

   logic w_idle;
   logic w_grant0;
   logic w_grant1;
   logic w_accept0;
   logic w_accept1;
   logic w_bit_end;

   assign w_idle = (r_state == S_IDLE);

   // Round-robin: a lone requester always wins.
   // On a tie, the requester that was not served last wins.
   assign w_grant0 = i_req0_valid & (~i_req1_valid | r_last_served);
   assign w_grant1 = i_req1_valid & (~i_req0_valid | ~r_last_served);

   assign o_req0_ready = i_clr & w_idle & w_grant0;
   assign o_req1_ready = i_clr & w_idle & w_grant1;

   assign w_accept0 = i_req0_valid & o_req0_ready;
   assign w_accept1 = i_req1_valid & o_req1_ready;

   assign w_bit_end = (r_cyc_cnt == LAST_CYC);

   // Next-state and next-output logic.
   // o_serial_out is registered, so the value the line carries during a
   // state is loaded on the edge that enters that state (or that bit).
   always_comb begin
      w_state_nxt    = r_state;
      w_cyc_nxt      = r_cyc_cnt;
      w_bit_nxt      = r_bit_cnt;
      w_shift_nxt    = r_shift;
      w_serial_nxt   = r_serial;
      w_grant_id_nxt = r_grant_id;
      w_last_nxt     = r_last_served;

      case (r_state)
         S_IDLE: begin
            w_cyc_nxt    = '0;
            w_bit_nxt    = 3'd0;
            w_serial_nxt = 1'b1;
            if (w_accept0) begin
               w_shift_nxt    = i_req0_data;
               w_grant_id_nxt = 1'b0;
               w_last_nxt     = 1'b0;
               w_state_nxt    = S_START;
               w_serial_nxt   = 1'b0;
            end else if (w_accept1) begin
               w_shift_nxt    = i_req1_data;
               w_grant_id_nxt = 1'b1;
               w_last_nxt     = 1'b1;
               w_state_nxt    = S_START;
               w_serial_nxt   = 1'b0;
            end
         end

         S_START: begin
            if (w_bit_end) begin
               w_cyc_nxt    = '0;
               w_state_nxt  = S_DATA;
               w_serial_nxt = r_shift[0];
            end else begin
               w_cyc_nxt = r_cyc_cnt + CW'(1);
            end
         end

         S_DATA: begin
            if (w_bit_end) begin
               w_cyc_nxt = '0;
               if (r_bit_cnt == 3'd7) begin
                  w_state_nxt  = S_STOP;
                  w_serial_nxt = 1'b1;
               end else begin
                  // Next bit is shift[1] now; shifting keeps shift[0]
                  // equal to the bit on the line.
                  w_shift_nxt  = {1'b0, r_shift[7:1]};
                  w_serial_nxt = r_shift[1];
                  w_bit_nxt    = r_bit_cnt + 3'd1;
               end
            end else begin
               w_cyc_nxt = r_cyc_cnt + CW'(1);
            end
         end

         S_STOP: begin
            if (w_bit_end) begin
               // Returning to IDLE guarantees at least one idle-high cycle
               // before the next start bit.
               w_cyc_nxt    = '0;
               w_state_nxt  = S_IDLE;
               w_serial_nxt = 1'b1;
            end else begin
               w_cyc_nxt = r_cyc_cnt + CW'(1);
            end
         end

         default: begin
            w_state_nxt  = S_IDLE;
            w_cyc_nxt    = '0;
            w_bit_nxt    = 3'd0;
            w_serial_nxt = 1'b1;
         end
      endcase
   end

   // State register.
   // An asynchronous clear aborts any frame and drives the line high at once.
   always_ff @(posedge i_clk or negedge i_clr) begin
      if (!i_clr) begin
         r_state       <= S_IDLE;
         r_cyc_cnt     <= '0;
         r_bit_cnt     <= 3'd0;
         r_shift       <= 8'h00;
         r_serial      <= 1'b1;
         r_grant_id    <= 1'b0;
         r_last_served <= 1'b1;
      end else begin
         r_state       <= w_state_nxt;
         r_cyc_cnt     <= w_cyc_nxt;
         r_bit_cnt     <= w_bit_nxt;
         r_shift       <= w_shift_nxt;
         r_serial      <= w_serial_nxt;
         r_grant_id    <= w_grant_id_nxt;
         r_last_served <= w_last_nxt;
      end
   end

   assign o_serial_out = r_serial;
   assign o_busy       = ~w_idle;
   assign o_grant_id   = r_grant_id;
   assign o_state      = r_state;

endmodule

// File: tb/tb_uart_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_sched
//   Directed testbench for uart_tx_sched with CLKS_PER_BIT = 4.
//
//   A table of request records holds the inputs and the hand-computed results:
//     - which ready should rise;
//     - which byte should be framed;
//     - which grant id should show.
//   Records are applied back to back from IDLE.
//   Hand-written sequences cover reset, withdrawal and mid-frame abort.
//
//   Outputs are sampled on the falling clock edge. Inputs are driven there too.
// -----------------------------------------------------------------------------
module tb_uart_tx_sched;

   localparam int CPB = 4;

   logic       clk;
   logic       clr;
   logic       req0_valid;
   logic [7:0] req0_data;
   logic       req0_ready;
   logic       req1_valid;
   logic [7:0] req1_data;
   logic       req1_ready;
   logic       serial_out;
   logic       busy;
   logic       grant_id;
   logic [1:0] state;

   int n_checks = 0;
   int n_fail   = 0;

   uart_tx_sched #(.CLKS_PER_BIT(CPB)) dut (
      .i_clk        (clk),
      .i_clr        (clr),
      .i_req0_valid (req0_valid),
      .i_req0_data  (req0_data),
      .o_req0_ready (req0_ready),
      .i_req1_valid (req1_valid),
      .i_req1_data  (req1_data),
      .o_req1_ready (req1_ready),
      .o_serial_out (serial_out),
      .o_busy       (busy),
      .o_grant_id   (grant_id),
      .o_state      (state)
   );

   // ---------------------------------------------------------------- clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- checks
   task automatic chk1(input string nm, input logic act, input logic exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk2(input string nm, input logic [1:0] act, input logic [1:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Expected line level c cycles into a frame carrying byte d.
   function automatic logic exp_bit(input logic [7:0] d, input int c);
      int idx;
      idx = c / CPB;
      if (idx == 0) return 1'b0;
      if (idx >= 9) return 1'b1;
      return d[idx-1];
   endfunction

   // Called at the falling edge of the first frame cycle.
   // Checks the whole frame, then the single IDLE cycle after it.
   // With pulse0 set, req0_valid rises and falls mid-frame.
   task automatic check_frame(input logic [7:0] d, input logic gid, input logic pulse0);
      for (int c = 0; c < 10*CPB; c++) begin
         chk1($sformatf("serial %02h c%0d", d, c), serial_out, exp_bit(d, c));
         chk1($sformatf("busy %02h c%0d", d, c), busy, 1'b1);
         chk1($sformatf("gid %02h c%0d", d, c), grant_id, gid);
         chk1($sformatf("ready0 in frame c%0d", c), req0_ready, 1'b0);
         chk1($sformatf("ready1 in frame c%0d", c), req1_ready, 1'b0);
         if (pulse0 && c == 8) begin
            req0_valid = 1'b1;
            req0_data  = 8'h77;
         end
         if (pulse0 && c == 20) req0_valid = 1'b0;
         @(negedge clk);
      end
      chk1($sformatf("idle serial after %02h", d), serial_out, 1'b1);
      chk1($sformatf("idle busy after %02h", d), busy, 1'b0);
      chk2($sformatf("idle state after %02h", d), state, 2'd0);
   endtask

   // ---------------------------------------------------------------- table
   typedef struct {
      logic       v0;
      logic [7:0] d0;
      logic       v1;
      logic [7:0] d1;
      logic       exp_r0;
      logic       exp_r1;
      logic [7:0] exp_byte;
      logic       exp_gid;
   } vec_t;

   vec_t vecs[7];

   initial begin
      // Requester 0 alone: 0x0B -> line 0,1,1,0,1,0,0,0,0,1.
      vecs[0] = '{1'b1, 8'h0B, 1'b0, 8'h00, 1'b1, 1'b0, 8'h0B, 1'b0};
      // Requester 1 alone; last_served becomes 1.
      vecs[1] = '{1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1};
      // Tie with both held: 0xA5, 0x3C, 0xA5.
      vecs[2] = '{1'b1, 8'hA5, 1'b1, 8'h3C, 1'b1, 1'b0, 8'hA5, 1'b0};
      vecs[3] = '{1'b1, 8'hA5, 1'b1, 8'h3C, 1'b0, 1'b1, 8'h3C, 1'b1};
      vecs[4] = '{1'b1, 8'hA5, 1'b1, 8'h3C, 1'b1, 1'b0, 8'hA5, 1'b0};
      // Requester 1 back to back: 0xFF then 0x00.
      vecs[5] = '{1'b0, 8'h00, 1'b1, 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1};
      vecs[6] = '{1'b0, 8'h00, 1'b1, 8'h00, 1'b0, 1'b1, 8'h00, 1'b1};
   end

   // ---------------------------------------------------------------- test
   initial begin
      clr        = 1'b1;
      req0_valid = 1'b1;
      req0_data  = 8'h11;
      req1_valid = 1'b1;
      req1_data  = 8'h22;
      #2 clr = 1'b0;

      // T1: reset with both requesters valid.
      repeat (3) begin
         @(negedge clk);
         chk1("rst serial", serial_out, 1'b1);
         chk1("rst busy",   busy,       1'b0);
         chk1("rst ready0", req0_ready, 1'b0);
         chk1("rst ready1", req1_ready, 1'b0);
         chk1("rst gid",    grant_id,   1'b0);
         chk2("rst state",  state,      2'd0);
      end
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      clr        = 1'b1;
      @(negedge clk);
      chk1("post-rst serial", serial_out, 1'b1);
      chk1("post-rst busy",   busy,       1'b0);

      // Table: each record is applied in the IDLE cycle that follows the previous frame.
      for (int i = 0; i < 7; i++) begin
         req0_valid = vecs[i].v0;
         req0_data  = vecs[i].d0;
         req1_valid = vecs[i].v1;
         req1_data  = vecs[i].d1;
         #1;
         chk1($sformatf("vec%0d ready0", i), req0_ready, vecs[i].exp_r0);
         chk1($sformatf("vec%0d ready1", i), req1_ready, vecs[i].exp_r1);
         @(posedge clk);
         @(negedge clk);
         check_frame(vecs[i].exp_byte, vecs[i].exp_gid, 1'b0);
      end

      // T6: withdrawal. req0_valid pulses during a frame and drops before IDLE.
      req0_valid = 1'b0;
      req1_valid = 1'b1;
      req1_data  = 8'h5A;
      #1;
      chk1("wd ready1", req1_ready, 1'b1);
      chk1("wd ready0", req0_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      req1_valid = 1'b0;
      check_frame(8'h5A, 1'b1, 1'b1);
      repeat (5) begin
         @(negedge clk);
         chk1("wd no ready0", req0_ready, 1'b0);
         chk1("wd no ready1", req1_ready, 1'b0);
         chk1("wd no frame busy", busy, 1'b0);
         chk1("wd line high", serial_out, 1'b1);
      end

      // T4: abort during DATA bit 3 of 0x33 (that bit is 0).
      req1_valid = 1'b1;
      req1_data  = 8'h33;
      #1;
      chk1("ab ready1", req1_ready, 1'b1);
      @(posedge clk);
      @(negedge clk);
      for (int c = 0; c < 17; c++) begin
         chk1($sformatf("ab serial c%0d", c), serial_out, exp_bit(8'h33, c));
         @(negedge clk);
      end
      chk1("ab pre serial", serial_out, 1'b0);
      chk1("ab pre gid", grant_id, 1'b1);
      clr = 1'b0;
      #1;
      chk1("ab serial", serial_out, 1'b1);
      chk1("ab busy", busy, 1'b0);
      chk1("ab gid", grant_id, 1'b0);
      chk1("ab ready1 in reset", req1_ready, 1'b0);
      chk2("ab state", state, 2'd0);
      repeat (2) begin
         @(negedge clk);
         chk1("ab hold serial", serial_out, 1'b1);
         chk1("ab hold ready1", req1_ready, 1'b0);
      end
      clr = 1'b1;
      // After the clear, requester 0 wins the first tie.
      req0_valid = 1'b1;
      req0_data  = 8'h55;
      req1_data  = 8'hC3;
      #1;
      chk1("ab tie ready0", req0_ready, 1'b1);
      chk1("ab tie ready1", req1_ready, 1'b0);
      @(posedge clk);
      @(negedge clk);
      check_frame(8'h55, 1'b0, 1'b0);

      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
